// File: rtl/cpu_timing_sequencer.sv
// Beat generator (one-hot T0..T7) and opcode decoder for the CPU control path.
// Fetch occupies T0..T2, execute T3..T7; supports free-run, single-step and HLT.
module cpu_timing_sequencer #(
    parameter int BEAT_DIV = 1,
    parameter int IR_W     = 8,
    parameter int ICNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              step,
    input  logic [IR_W-1:0]   ir,
    output logic [7:0]        t,
    output logic              ld,
    output logic              add,
    output logic              sub,
    output logic              and_op,
    output logic              or_op,
    output logic              sto,
    output logic              busy,
    output logic              halted,
    output logic              instr_done,
    output logic [ICNT_W-1:0] icount
);

    localparam int DIV_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BEAT_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_HALT
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [DIV_W-1:0] div;
    logic             exec_valid;
    logic [2:0]       opcode;
    logic             active;
    logic             next_active;
    logic             beat_end;
    logic             last_beat;
    logic             hlt_end;
    logic             retire;
    logic [7:0]       next_t;
    logic             unused_ir_bits;

    assign opcode         = ir[IR_W-1 -: 3];
    assign unused_ir_bits = ^ir[IR_W-4:0];

    assign active      = (state == ST_RUN) || (state == ST_STEP);
    assign next_active = (next_state == ST_RUN) || (next_state == ST_STEP);
    assign beat_end    = active && (div == DIV_LAST);
    assign last_beat   = beat_end && t[7];
    // HLT retires at the end of T3; T4..T7 are never issued for it
    assign hlt_end     = beat_end && t[3] && (opcode == 3'b111);
    assign retire      = last_beat || hlt_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (run) begin
                    next_state = ST_RUN;
                end else if (step) begin
                    next_state = ST_STEP;
                end
            end
            ST_RUN, ST_STEP: begin
                if (hlt_end) begin
                    next_state = ST_HALT;
                end else if (last_beat) begin
                    next_state = run ? ST_RUN : ST_IDLE;
                end
            end
            default: next_state = ST_HALT;
        endcase
    end

    always_comb begin
        ld     = 1'b0;
        add    = 1'b0;
        sub    = 1'b0;
        and_op = 1'b0;
        or_op  = 1'b0;
        sto    = 1'b0;
        if (exec_valid) begin
            case (opcode)
                3'b001:  ld     = 1'b1;
                3'b010:  add    = 1'b1;
                3'b011:  sub    = 1'b1;
                3'b100:  and_op = 1'b1;
                3'b101:  or_op  = 1'b1;
                3'b110:  sto    = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        next_t = t;
        if (!next_active) begin
            next_t = 8'h00;
        end else if (!active) begin
            next_t = 8'h01;
        end else if (beat_end) begin
            next_t = {t[6:0], t[7]};
        end
    end

    // exec_valid tracks the registered beat, so it is high exactly while t is in T3..T7
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div        <= '0;
            t          <= 8'h00;
            exec_valid <= 1'b0;
            instr_done <= 1'b0;
            icount     <= '0;
            busy       <= 1'b0;
            halted     <= 1'b0;
        end else begin
            div        <= (active && next_active && !beat_end) ? div + 1'b1 : '0;
            t          <= next_t;
            exec_valid <= |next_t[7:3];
            instr_done <= retire;
            icount     <= icount + {{(ICNT_W-1){1'b0}}, retire};
            busy       <= next_active;
            halted     <= (next_state == ST_HALT);
        end
    end

endmodule

// File: tb/tb_cpu_timing_sequencer.sv
// Self-checking bench for cpu_timing_sequencer: directed vector table, hand sequences
// for multi-cycle corners, and random stimulus against a cycle-count reference model.
module tb_cpu_timing_sequencer;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;
    localparam int M_HALT = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       step;
    logic [7:0] ir;

    logic [7:0]  t1, t3;
    logic        ld1, add1, sub1, and1, or1, sto1, busy1, halt1, done1;
    logic        ld3, add3, sub3, and3, or3, sto3, busy3, halt3, done3;
    logic [3:0]  icnt1;
    logic [15:0] icnt3;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit         run;
        bit         step;
        logic [7:0] ir;
        logic [7:0] t;
        logic [5:0] sb;
        bit         busy;
        bit         done;
        int         icnt;
    } vec_t;

    typedef struct {
        int mode;
        int cyc;
        int cnt;
        bit done;
    } mdl_t;

    vec_t       tbl[17];
    mdl_t       m1, m3;
    int         cnt_a, cnt_b, cnt_c, cnt_d;
    logic [3:0] ic15, ic16;
    bit         saw_a;
    logic [2:0] newop;

    always #5 clk = ~clk;

    cpu_timing_sequencer #(.BEAT_DIV(1), .IR_W(8), .ICNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .ir(ir),
        .t(t1), .ld(ld1), .add(add1), .sub(sub1), .and_op(and1), .or_op(or1), .sto(sto1),
        .busy(busy1), .halted(halt1), .instr_done(done1), .icount(icnt1)
    );

    cpu_timing_sequencer #(.BEAT_DIV(3), .IR_W(8), .ICNT_W(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .ir(ir),
        .t(t3), .ld(ld3), .add(add3), .sub(sub3), .and_op(and3), .or_op(or3), .sto(sto3),
        .busy(busy3), .halted(halt3), .instr_done(done3), .icount(icnt3)
    );

    function automatic logic [63:0] pk(logic [7:0] tt, logic [5:0] sb, logic b, logic h,
                                       logic d, logic [31:0] ic);
        return 64'({tt, sb, b, h, d, ic});
    endfunction

    function automatic logic [63:0] act1();
        return pk(t1, {ld1, add1, sub1, and1, or1, sto1}, busy1, halt1, done1, 32'(icnt1));
    endfunction

    function automatic logic [63:0] act3();
        return pk(t3, {ld3, add3, sub3, and3, or3, sto3}, busy3, halt3, done3, 32'(icnt3));
    endfunction

    // Reference model: position inside the instruction is a plain clock count
    function automatic mdl_t mstep(mdl_t m, int d, bit r, bit s, logic [2:0] op);
        mdl_t n;
        n      = m;
        n.done = 1'b0;
        case (m.mode)
            M_IDLE: begin
                if (r) begin
                    n.mode = M_RUN;  n.cyc = 0;
                end else if (s) begin
                    n.mode = M_STEP; n.cyc = 0;
                end
            end
            M_RUN, M_STEP: begin
                if (m.cyc / d == 3 && m.cyc % d == d - 1 && op == 3'b111) begin
                    n.mode = M_HALT; n.done = 1'b1; n.cnt = m.cnt + 1;
                end else if (m.cyc == 8 * d - 1) begin
                    n.done = 1'b1; n.cnt = m.cnt + 1; n.cyc = 0;
                    n.mode = r ? M_RUN : M_IDLE;
                end else begin
                    n.cyc = m.cyc + 1;
                end
            end
            default: ;
        endcase
        return n;
    endfunction

    function automatic logic [63:0] mexp(mdl_t m, int d, int w, logic [2:0] op);
        bit         bz;
        logic [7:0] tt;
        logic [5:0] sb;
        bz = (m.mode == M_RUN) || (m.mode == M_STEP);
        tt = bz ? 8'(1 << (m.cyc / d)) : 8'h00;
        sb = 6'd0;
        if (bz && m.cyc / d >= 3 && op >= 3'd1 && op <= 3'd6) sb = 6'(32 >> (int'(op) - 1));
        return pk(tt, sb, bz, m.mode == M_HALT, m.done, 32'(m.cnt % (1 << w)));
    endfunction

    function automatic bit canChange(mdl_t m, int d);
        return !((m.mode == M_RUN || m.mode == M_STEP) && m.cyc / d >= 3);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit s, input logic [7:0] i);
        run  = r;
        step = s;
        ir   = i;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_d1", act1(), pk(8'h00, 6'd0, 0, 0, 0, 0));
        checkOutput("reset_d3", act3(), pk(8'h00, 6'd0, 0, 0, 0, 0));
        tick();
        rst_n = 1'b1;

        // LD under free-run: two instructions, run dropped after the first retires
        for (int i = 0; i < 17; i++) begin
            tbl[i].run  = (i <= 8);
            tbl[i].step = 1'b0;
            tbl[i].ir   = 8'h20;
            tbl[i].busy = (i <= 15);
            tbl[i].done = (i == 8) || (i == 16);
            tbl[i].icnt = (i < 8) ? 0 : ((i < 16) ? 1 : 2);
            tbl[i].t    = (i == 16) ? 8'h00 : 8'(1 << (i % 8));
            tbl[i].sb   = ((i % 8) >= 3 && i != 16) ? 6'b100000 : 6'd0;
        end
        for (int i = 0; i < 17; i++) begin
            applyStimulus(tbl[i].run, tbl[i].step, tbl[i].ir);
            tick();
            checkOutput($sformatf("tbl%0d", i), act1(),
                        pk(tbl[i].t, tbl[i].sb, tbl[i].busy, 0, tbl[i].done, tbl[i].icnt));
        end

        // ADD with run held for one clk only
        doReset();
        applyStimulus(1'b1, 1'b0, 8'h40);
        tick();
        checkOutput("add_t0", act1(), pk(8'h01, 6'd0, 1, 0, 0, 0));
        applyStimulus(1'b0, 1'b0, 8'h40);
        for (int b = 1; b < 8; b++) begin
            tick();
            checkOutput($sformatf("add_beat%0d", b), act1(),
                        pk(8'(1 << b), (b >= 3) ? 6'b010000 : 6'd0, 1, 0, 0, 0));
        end
        tick();
        checkOutput("add_end", act1(), pk(8'h00, 6'd0, 0, 0, 1, 1));

        // SUB single-step twice; a step during T5 is ignored
        doReset();
        for (int rep = 1; rep <= 2; rep++) begin
            applyStimulus(1'b0, 1'b1, 8'h60);
            tick();
            checkOutput($sformatf("step%0d_t0", rep), act1(), pk(8'h01, 6'd0, 1, 0, 0, rep - 1));
            for (int b = 1; b < 8; b++) begin
                applyStimulus(1'b0, b == 6, 8'h60);
                tick();
                checkOutput($sformatf("step%0d_beat%0d", rep, b), act1(),
                            pk(8'(1 << b), (b >= 3) ? 6'b001000 : 6'd0, 1, 0, 0, rep - 1));
            end
            applyStimulus(1'b0, 1'b0, 8'h60);
            tick();
            checkOutput($sformatf("step%0d_end", rep), act1(), pk(8'h00, 6'd0, 0, 0, 1, rep));
            tick();
            checkOutput($sformatf("step%0d_idle", rep), act1(), pk(8'h00, 6'd0, 0, 0, 0, rep));
        end

        // HLT stops after T3 and ignores run until reset
        doReset();
        applyStimulus(1'b1, 1'b0, 8'hE0);
        for (int b = 0; b < 4; b++) begin
            tick();
            checkOutput($sformatf("hlt_beat%0d", b), act1(), pk(8'(1 << b), 6'd0, 1, 0, 0, 0));
        end
        tick();
        checkOutput("hlt_enter", act1(), pk(8'h00, 6'd0, 0, 1, 1, 1));
        saw_a = 1'b0;
        cnt_a = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (t1 != 8'h00) saw_a = 1'b1;
            if (done1) cnt_a++;
        end
        checkOutput("hlt_hold", 64'({saw_a, cnt_a[7:0], halt1, icnt1}), 64'({1'b0, 8'd0, 1'b1, 4'd1}));
        rst_n = 1'b0;
        #1;
        checkOutput("hlt_reset", act1(), pk(8'h00, 6'd0, 0, 0, 0, 0));
        tick();
        rst_n = 1'b1;

        // STO with three clks per beat
        doReset();
        applyStimulus(1'b1, 1'b0, 8'hC0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'hC0);
        cnt_a = 1; cnt_b = 0; cnt_c = 1; cnt_d = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (t3 == 8'h00) break;
            cnt_a++;
            if (sto3) cnt_b++;
            if (t3 == 8'h01) cnt_c++;
            if (t3 == 8'h80) cnt_d++;
        end
        checkOutput("div3_busy_clks", 64'(cnt_a), 64'd24);
        checkOutput("div3_sto_clks", 64'(cnt_b), 64'd15);
        checkOutput("div3_beat_hold", 64'({cnt_c[7:0], cnt_d[7:0]}), 64'({8'd3, 8'd3}));
        checkOutput("div3_retired", 64'(icnt3), 64'd1);

        // Async reset mid-T5 of the second instruction
        doReset();
        applyStimulus(1'b1, 1'b0, 8'h20);
        for (int i = 0; i < 14; i++) tick();
        checkOutput("arst_pre", act1(), pk(8'h20, 6'b100000, 1, 0, 0, 1));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_now", act1(), pk(8'h00, 6'd0, 0, 0, 0, 0));
        tick();
        rst_n = 1'b1;

        // 16 NOPs wrap the 4-bit counter
        applyStimulus(1'b1, 1'b0, 8'h00);
        cnt_a = 0; saw_a = 1'b0; ic15 = 4'hX; ic16 = 4'hX;
        for (int i = 0; i < 200 && cnt_a < 16; i++) begin
            tick();
            if (ld1 | add1 | sub1 | and1 | or1 | sto1) saw_a = 1'b1;
            if (done1) begin
                cnt_a++;
                if (cnt_a == 15) ic15 = icnt1;
                if (cnt_a == 16) ic16 = icnt1;
            end
        end
        checkOutput("nop_count", 64'(cnt_a), 64'd16);
        checkOutput("nop_icnt15", 64'(ic15), 64'd15);
        checkOutput("nop_wrap", 64'(ic16), 64'd0);
        checkOutput("nop_no_strobe", 64'(saw_a), 64'd0);

        // Random stimulus on both instances against the reference model
        doReset();
        m1 = '{M_IDLE, 0, 0, 1'b0};
        m3 = '{M_IDLE, 0, 0, 1'b0};
        for (int it = 0; it < 3000; it++) begin
            if ($urandom % 16 == 0) run = ~run;
            step = ($urandom % 6 == 0);
            if (canChange(m1, 1) && canChange(m3, 3) && $urandom % 3 == 0) begin
                newop = 3'($urandom % 8);
                if (newop == 3'b111 && $urandom % 3 != 0) newop = 3'b000;
                ir = {newop, 5'($urandom)};
            end
            if ((m1.mode == M_HALT && m3.mode == M_HALT) || $urandom % 300 == 0) begin
                rst_n = 1'b0;
                m1    = '{M_IDLE, 0, 0, 1'b0};
                m3    = '{M_IDLE, 0, 0, 1'b0};
            end
            tick();
            if (rst_n) begin
                m1 = mstep(m1, 1, run, step, ir[7:5]);
                m3 = mstep(m3, 3, run, step, ir[7:5]);
            end
            checkOutput($sformatf("rand_d1_%0d", it), act1(), mexp(m1, 1, 4, ir[7:5]));
            checkOutput($sformatf("rand_d3_%0d", it), act3(), mexp(m3, 3, 16, ir[7:5]));
            rst_n = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
